// File: rtl/cora_window_pkg.sv
// Shared types and default sizing for the keyword-training windower.
package cora_window_pkg;

    localparam int DEF_NUM_CH          = 16;
    localparam int DEF_BIN_CYCLES      = 100;
    localparam int DEF_MAX_BINS        = 300;
    localparam int DEF_WIN_BINS        = 50;
    localparam int DEF_MIN_BINS        = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_NUM_EXAMPLES    = 15;

    typedef logic [DEF_NUM_CH-1:0] bin_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PREP,
        ST_EMIT
    } win_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-to-talk debouncer: 2-flop synchroniser, stability counter and
// single-cycle press/release pulses derived from the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic pressed,
    output logic released
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             btn_db;
    logic             btn_db_d;
    logic [CNT_W-1:0] stable_cnt;

    // The level only flips after DEBOUNCE_CYCLES back-to-back cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            btn_db     <= 1'b0;
            btn_db_d   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_q   <= {sync_q[0], button_raw};
            btn_db_d <= btn_db;
            if (sync_q[1] != btn_db) begin
                if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db     <= sync_q[1];
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign pressed  = btn_db & ~btn_db_d;
    assign released = ~btn_db & btn_db_d;

endmodule

// File: rtl/utterance_windower.sv
// Records spike occupancy bins while push-to-talk is held, then resamples the
// utterance to a fixed window streamed out over valid/ready.
module utterance_windower
    import cora_window_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int BIN_CYCLES      = DEF_BIN_CYCLES,
    parameter int MAX_BINS        = DEF_MAX_BINS,
    parameter int WIN_BINS        = DEF_WIN_BINS,
    parameter int MIN_BINS        = DEF_MIN_BINS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_EXAMPLES    = DEF_NUM_EXAMPLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             button_raw,
    input  logic                             spike_valid,
    input  logic [$clog2(NUM_CH)-1:0]        channel_id,
    input  logic                             mode,
    input  logic                             abort,
    input  logic                             clear_count,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [NUM_CH-1:0]                win_data,
    output logic [$clog2(WIN_BINS)-1:0]      win_index,
    output logic                             win_last,
    output logic                             win_mode,
    output logic                             busy,
    output logic [$clog2(MAX_BINS+1)-1:0]    utt_len,
    output logic                             rec_overflow,
    output logic                             reject_short,
    output logic [$clog2(NUM_EXAMPLES+1)-1:0] example_count,
    output logic                             train_done
);

    localparam int IDX_W = $clog2(WIN_BINS);
    localparam int LEN_W = $clog2(MAX_BINS + 1);
    localparam int CNT_W = $clog2(NUM_EXAMPLES + 1);
    localparam int BC_W  = $clog2(BIN_CYCLES + 1);
    localparam int ACC_W = $clog2(WIN_BINS) + 1;

    win_state_t        state, next_state;
    logic              pressed, released;
    logic [LEN_W-1:0]  len, len_next, rem, q_bins, src;
    logic [ACC_W-1:0]  r_bins, acc, acc_sum;
    logic [BC_W-1:0]   bin_cnt;
    logic [NUM_CH-1:0] cur_bin, spike_bit;
    logic [NUM_CH-1:0] mem [MAX_BINS];
    logic              tick, accept, ovf_evt, rej_evt, rec_exit, win_end;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_raw (button_raw),
        .pressed    (pressed),
        .released   (released)
    );

    always_comb begin
        spike_bit = '0;
        if (spike_valid && (32'(channel_id) < NUM_CH))
            spike_bit[channel_id] = 1'b1;
    end

    assign tick     = (state == ST_RECORD) && (bin_cnt == BC_W'(BIN_CYCLES - 1));
    assign len_next = tick ? len + LEN_W'(1) : len;
    assign accept   = (state == ST_EMIT) && win_ready;
    assign acc_sum  = acc + r_bins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // A tick is folded into len before release is judged; overflow beats release.
    always_comb begin
        next_state = state;
        ovf_evt    = 1'b0;
        rej_evt    = 1'b0;
        rec_exit   = 1'b0;
        win_end    = 1'b0;
        case (state)
            ST_IDLE:   if (pressed) next_state = ST_RECORD;
            ST_RECORD: begin
                if (tick && (len_next == LEN_W'(MAX_BINS))) begin
                    ovf_evt    = 1'b1;
                    rec_exit   = 1'b1;
                    next_state = ST_PREP;
                end else if (released) begin
                    rec_exit = 1'b1;
                    if (len_next < LEN_W'(MIN_BINS)) begin
                        rej_evt    = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_PREP;
                    end
                end
            end
            ST_PREP:   if (rem < LEN_W'(WIN_BINS)) next_state = ST_EMIT;
            ST_EMIT: begin
                if (accept && (win_index == IDX_W'(WIN_BINS - 1))) begin
                    win_end    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
            ovf_evt    = 1'b0;
            rej_evt    = 1'b0;
            rec_exit   = 1'b0;
            win_end    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tick) mem[len] <= cur_bin | spike_bit;
    end

    // PREP divides len by WIN_BINS by repeated subtraction; EMIT steps src by q plus carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len          <= '0;
            rem          <= '0;
            q_bins       <= '0;
            r_bins       <= '0;
            src          <= '0;
            acc          <= '0;
            bin_cnt      <= '0;
            cur_bin      <= '0;
            win_index    <= '0;
            win_mode     <= 1'b0;
            utt_len      <= '0;
            rec_overflow <= 1'b0;
            reject_short <= 1'b0;
        end else begin
            rec_overflow <= ovf_evt;
            reject_short <= rej_evt;
            case (state)
                ST_IDLE: begin
                    if (pressed && !abort) begin
                        len      <= '0;
                        cur_bin  <= '0;
                        bin_cnt  <= '0;
                        win_mode <= mode;
                    end
                end
                ST_RECORD: begin
                    if (tick) begin
                        len     <= len_next;
                        cur_bin <= '0;
                        bin_cnt <= '0;
                    end else begin
                        cur_bin <= cur_bin | spike_bit;
                        bin_cnt <= bin_cnt + BC_W'(1);
                    end
                    if (rec_exit) begin
                        utt_len <= len_next;
                        rem     <= len_next;
                        q_bins  <= '0;
                    end
                end
                ST_PREP: begin
                    if (rem >= LEN_W'(WIN_BINS)) begin
                        rem    <= rem - LEN_W'(WIN_BINS);
                        q_bins <= q_bins + LEN_W'(1);
                    end else begin
                        r_bins    <= ACC_W'(rem);
                        src       <= '0;
                        acc       <= '0;
                        win_index <= '0;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (acc_sum >= ACC_W'(WIN_BINS)) begin
                            acc <= acc_sum - ACC_W'(WIN_BINS);
                            src <= src + q_bins + LEN_W'(1);
                        end else begin
                            acc <= acc_sum;
                            src <= src + q_bins;
                        end
                        win_index <= win_end ? '0 : win_index + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            example_count <= '0;
        else if (clear_count)
            example_count <= '0;
        else if (win_end && !win_mode && (example_count < CNT_W'(NUM_EXAMPLES)))
            example_count <= example_count + CNT_W'(1);
    end

    assign train_done = (example_count == CNT_W'(NUM_EXAMPLES));
    assign busy       = (state != ST_IDLE);
    assign win_valid  = (state == ST_EMIT);
    assign win_data   = win_valid ? mem[src] : '0;
    assign win_last   = win_valid && (win_index == IDX_W'(WIN_BINS - 1));

endmodule

// File: tb/tb_utterance_windower.sv
// Scoreboard bench: directed utterances push expected beats; a monitor pops and
// compares each accepted beat and checks hold stability during stalls.
module tb_utterance_windower;

    localparam int NCH  = 16;
    localparam int BIN  = 16;
    localparam int MAXB = 300;
    localparam int WIN  = 50;
    localparam int MINB = 5;
    localparam int DEB  = 16;
    localparam int NEX  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        button_raw = 1'b0;
    logic        spike_valid = 1'b0;
    logic [3:0]  channel_id = '0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic        clear_count = 1'b0;
    logic        win_valid;
    logic        win_ready = 1'b1;
    logic [15:0] win_data;
    logic [5:0]  win_index;
    logic        win_last;
    logic        win_mode;
    logic        busy;
    logic [8:0]  utt_len;
    logic        rec_overflow;
    logic        reject_short;
    logic [3:0]  example_count;
    logic        train_done;

    int n_checks = 0, n_fail = 0;
    int beats_seen = 0, cyc = 0, t_len = 0, prep_meas = -1;
    int ovf_cnt = 0, rej_cnt = 0, valid_cyc = 0, busy_rises = 0;
    logic [31:0] exp_q[$];

    utterance_windower #(
        .NUM_CH(NCH), .BIN_CYCLES(BIN), .MAX_BINS(MAXB), .WIN_BINS(WIN),
        .MIN_BINS(MINB), .DEBOUNCE_CYCLES(DEB), .NUM_EXAMPLES(NEX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_raw(button_raw), .spike_valid(spike_valid),
        .channel_id(channel_id), .mode(mode), .abort(abort), .clear_count(clear_count),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_index(win_index), .win_last(win_last), .win_mode(win_mode), .busy(busy),
        .utt_len(utt_len), .rec_overflow(rec_overflow), .reject_short(reject_short),
        .example_count(example_count), .train_done(train_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
        end
    endtask

    // Bin k carries channels = bits of k on offsets 0..8, plus channel 12 on the tick cycle.
    task automatic pushWindow(input int len, input bit m, input bit dup, input int nbeats);
        logic [15:0] d;
        int k;
        for (int i = 0; i < nbeats; i++) begin
            k = (i * len) / WIN;
            d = dup ? 16'h0008 : (16'h1000 | 16'(k));
            exp_q.push_back({8'h00, d, 6'(i), 1'(i == WIN - 1), m});
        end
    endtask

    task automatic applyStimulus(input int nbins, input bit m, input bit dup, input bit hold_full);
        int n = 0;
        int total, c_rel, k, off;
        mode = m;
        button_raw = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!busy && n < 200);
        if (!busy) begin
            checkOutput("press_timeout", 0, 1);
            button_raw = 1'b0;
            return;
        end
        total = hold_full ? BIN * MAXB + 100 : BIN * nbins + 8;
        c_rel = BIN * nbins + 8 - (DEB + 2);
        for (int c = 0; c < total; c++) begin
            k = c / BIN;
            off = c % BIN;
            spike_valid = 1'b0;
            channel_id = '0;
            if (dup) begin
                if (off == 2 || off == 5) begin spike_valid = 1'b1; channel_id = 4'd3; end
            end else if (off < 9 && k[off]) begin
                spike_valid = 1'b1; channel_id = 4'(off);
            end else if (off == BIN - 1) begin
                spike_valid = 1'b1; channel_id = 4'd12;
            end
            if (!hold_full && c == c_rel) button_raw = 1'b0;
            @(posedge clk); #1;
        end
        spike_valid = 1'b0;
        button_raw = 1'b0;
    endtask

    task automatic waitIdle(input bit toggle);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            if (toggle) win_ready = ~win_ready;
            n++;
        end
        win_ready = 1'b1;
        if (n >= 3000) checkOutput("idle_timeout", 1, 0);
        repeat (DEB + 8) begin @(posedge clk); #1; end
    endtask

    initial begin : monitor
        logic [31:0] cur, held_val, e;
        bit held = 0;
        forever begin
            @(negedge clk);
            if (rst_n && win_valid) begin
                cur = {8'h00, win_data, win_index, win_last, win_mode};
                if (held) checkOutput("hold_stable", cur, held_val);
                if (win_ready) begin
                    if (exp_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", cur, e);
                    end
                    beats_seen++;
                    held = 0;
                end else begin
                    held = 1;
                    held_val = cur;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin : watcher
        logic busy_q = 1'b0, valid_q = 1'b0;
        logic [8:0] utt_q = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rec_overflow) ovf_cnt++;
            if (reject_short) rej_cnt++;
            if (win_valid) valid_cyc++;
            if (busy && !busy_q) busy_rises++;
            if (utt_len != utt_q) t_len = cyc;
            if (win_valid && !valid_q) prep_meas = cyc - t_len;
            busy_q = busy;
            utt_q = utt_len;
            valid_q = win_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin : main
        int base, n, v0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_win_valid", win_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_win_data", win_data, 0);
        checkOutput("rst_utt_len", utt_len, 0);
        checkOutput("rst_count", example_count, 0);
        checkOutput("rst_train_done", train_done, 0);
        checkOutput("rst_pulses", {rec_overflow, reject_short, win_last, win_mode}, 0);

        $display("[TB] glitch shorter than debounce");
        button_raw = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        button_raw = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        checkOutput("glitch_no_press", busy_rises, 0);

        $display("[TB] len 100 train");
        prep_meas = -1;
        pushWindow(100, 0, 0, WIN);
        applyStimulus(100, 0, 0, 0);
        waitIdle(0);
        checkOutput("len100_sb_empty", exp_q.size(), 0);
        checkOutput("len100_utt_len", utt_len, 100);
        checkOutput("len100_prep", prep_meas, 3);
        checkOutput("len100_count", example_count, 1);

        $display("[TB] len 75 train");
        prep_meas = -1;
        pushWindow(75, 0, 0, WIN);
        applyStimulus(75, 0, 0, 0);
        waitIdle(0);
        checkOutput("len75_sb_empty", exp_q.size(), 0);
        checkOutput("len75_prep", prep_meas, 2);
        checkOutput("len75_count", example_count, 2);

        $display("[TB] len 3 reject");
        v0 = valid_cyc;
        applyStimulus(3, 0, 0, 0);
        waitIdle(0);
        checkOutput("short_reject_pulse", rej_cnt, 1);
        checkOutput("short_no_valid", valid_cyc - v0, 0);
        checkOutput("short_utt_len", utt_len, 3);
        checkOutput("short_count", example_count, 2);

        $display("[TB] overflow infer");
        prep_meas = -1;
        pushWindow(MAXB, 1, 0, WIN);
        applyStimulus(MAXB, 1, 0, 1);
        waitIdle(0);
        checkOutput("ovf_pulse", ovf_cnt, 1);
        checkOutput("ovf_utt_len", utt_len, MAXB);
        checkOutput("ovf_prep", prep_meas, 7);
        checkOutput("ovf_sb_empty", exp_q.size(), 0);
        checkOutput("infer_count", example_count, 2);

        $display("[TB] duplicate channel spikes");
        pushWindow(MINB, 0, 1, WIN);
        applyStimulus(MINB, 0, 1, 0);
        waitIdle(0);
        checkOutput("dup_sb_empty", exp_q.size(), 0);
        checkOutput("dup_count", example_count, 3);

        $display("[TB] stalled handshake");
        pushWindow(50, 0, 0, WIN);
        applyStimulus(50, 0, 0, 0);
        waitIdle(1);
        checkOutput("stall_sb_empty", exp_q.size(), 0);
        checkOutput("stall_count", example_count, 4);

        $display("[TB] abort at beat 20");
        base = beats_seen;
        pushWindow(50, 0, 0, 20);
        applyStimulus(50, 0, 0, 0);
        n = 0;
        while (beats_seen < base + 20 && n < 500) begin @(posedge clk); #1; n++; end
        checkOutput("abort_reach_beat20", beats_seen - base, 20);
        abort = 1'b1;
        win_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_valid_drop", win_valid, 0);
        checkOutput("abort_busy", busy, 0);
        win_ready = 1'b1;
        waitIdle(0);
        checkOutput("abort_sb_empty", exp_q.size(), 0);
        checkOutput("abort_count", example_count, 4);

        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        checkOutput("clear1_count", example_count, 0);

        $display("[TB] sixteen train windows");
        for (int w = 1; w <= 16; w++) begin
            pushWindow(MINB, 0, 0, WIN);
            applyStimulus(MINB, 0, 0, 0);
            waitIdle(0);
            if (w == 14) checkOutput("w14_done", {example_count, train_done}, {4'd14, 1'b0});
            if (w >= 15) checkOutput("sat_count_done", {example_count, train_done}, {4'd15, 1'b1});
        end
        checkOutput("multi_sb_empty", exp_q.size(), 0);

        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        checkOutput("clear2_count_done", {example_count, train_done}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
